alu_exec_stage: RTL
===================

Name: alu_exec_stage

Overview:
- Execute-stage sequencer. Sits directly upstream of the combinational ALU and owns its operand/op inputs.
- Accepts one decoded ALU operation per handshake. Single-step ops pass through the ALU in one cycle. Shift/rotate by count N is iterated as N single-bit ALU steps, feeding the result back as the next operand.
- Registers the final result, merges ALU flags into the architectural PSW flag register under a per-op mask, and presents the result to writeback with valid/ready.

Parameters:
- CNT_MASK, 31, mask applied to shift/rotate count (in_b[4:0] & CNT_MASK).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept (state IDLE)
- in_op  in  5  ALU op code: AND=0 ADD=1 SUB=2 INC=3 DEC=4 NEG=5 ROL=6 ROR=7 ROLC=8 RORC=9 SHL=10 SHR=11 SHRA=12 SHLA=13
- in_size  in  1  0=byte, 1=word
- in_a  in  16  operand A
- in_b  in  16  operand B / shift count
- in_flag_mask  in  6  PSW bits this op may update; bit order AC=0 CY=1 V=2 P=3 S=4 Z=5
- flush  in  1  synchronous abort of the in-flight op
- alu_op  out  5  to ALU
- alu_size  out  1  to ALU
- alu_a  out  16  to ALU
- alu_b  out  16  to ALU
- alu_r  in  16  ALU result
- alu_flags  in  6  ALU flags
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- out_result  out  16  registered result
- psw_flags  out  6  architectural flag register

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; in_ready=1; out_valid=0; out_result=0; psw_flags=0.
  - alu_op=0, alu_size=0, alu_a=0, alu_b=0.
  - Applies at any point mid-operation; the in-flight op is discarded.
- Shift class is op 6..13. All other ops are single-step.
- States: IDLE, EXEC, DONE.
- IDLE:
  - Accept on in_valid & in_ready at edge E0. Latch op, size, mask, acc=in_a, b_reg=in_b.
  - steps = 1 for single-step ops; (in_b[4:0] & CNT_MASK) for shift class.
  - Shift count 0: go directly to DONE with out_result=in_a and PSW unchanged (effective mask=0).
  - Otherwise go to EXEC.
  - V bit of the mask is cleared when a shift-class count is not 1.
- EXEC:
  - Drive alu_op=op, alu_size=size, alu_a=acc.
  - alu_b = b_reg for single-step ops; 16'd1 for shift class.
  - Each edge: if size=0, acc <= {acc[15:8], alu_r[7:0]}; else acc <= alu_r. Then decrement steps.
  - On the edge where steps reaches 0: go to DONE, out_result <= new acc value, and update the PSW:
    psw_flags <= (psw_flags & ~mask) | (f & mask).
  - f is alu_flags from the final step, except in byte mode where f[Z] is replaced by (alu_r[7:0]==0).
- Latency: out_valid rises N edges after E0 (N=1 for single-step ops, N=count for shifts, 0 for a zero-count shift). Outside EXEC, alu_* outputs hold their last value.
- DONE:
  - out_valid=1 and out_result is stable until out_ready is sampled high; then go to IDLE.
  - in_ready is low in DONE, so there is no same-cycle accept.
- flush=1 at any edge: go to IDLE and drop out_valid. psw_flags is not updated for the aborted op. flush wins over a simultaneous accept, EXEC completion, or out_ready.
- in_valid is ignored unless in_ready=1.

Test Plan:
1. ADD word, A=0x7FFF, B=0x0001, mask=0x3F → out_valid 1 edge after accept; out_result=0x8000; psw V=1 S=1 Z=0 CY=0.
2. SHL byte, A=0x1281, B=3, mask=0x3F → 3 EXEC cycles with alu_b=1; out_result=0x1208; CY=0; V unchanged from its prior value; out_valid 3 edges after accept.
3. ROR word, A=0x0001, B=0 → out_valid the cycle after accept; out_result=0x0001; psw_flags unchanged.
4. SUB byte, A=0x0005, B=0x0005, mask=0x3B → Z=1 from byte recompute; V bit untouched; out_valid held across 3 cycles of out_ready=0, then a single-cycle retire.
5. SHR word, B=20: assert flush after 5 EXEC cycles → IDLE next cycle; out_valid never asserts; psw_flags unchanged. Then ADD accepted and completes normally.
6. Deassert reset_n mid-EXEC of a 10-step ROL → all outputs at reset values immediately; in_ready=1 after release.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage sequencer driving a combinational ALU, iterating shifts bit by bit
module alu_exec_stage #(
  parameter logic [4:0] CNT_MASK = 5'd31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic        in_size,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [5:0]  in_flag_mask,
  input  logic        flush,
  output logic [4:0]  alu_op,
  output logic        alu_size,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_r,
  input  logic [5:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [5:0]  psw_flags
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] mask_r, mask_in, f;
  logic [4:0] steps, cnt_in;
  logic [15:0] acc_nx;
  logic is_shift, accept, zero_cnt, last;
  assign is_shift = (in_op >= 5'd6) && (in_op <= 5'd13);
  assign cnt_in = in_b[4:0] & CNT_MASK;
  assign accept = in_valid && in_ready;
  assign zero_cnt = is_shift && (cnt_in == 5'd0);
  assign last = steps == 5'd1;
  // alu_a doubles as the accumulator while iterating
  assign acc_nx = alu_size ? alu_r : {alu_a[15:8], alu_r[7:0]};
  assign f = alu_size ? alu_flags : {alu_r[7:0] == 8'd0, alu_flags[4:0]};
  assign mask_in = (is_shift && cnt_in != 5'd1) ? (in_flag_mask & 6'b111011) : in_flag_mask;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? (zero_cnt ? DONE : EXEC) : IDLE;
      EXEC: state_nx = last ? DONE : EXEC;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      mask_r <= '0;
      steps <= '0;
      out_result <= '0;
      psw_flags <= '0;
      alu_op <= '0;
      alu_size <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
    end else begin
      state <= state_nx;
      if (!flush && accept) begin
        mask_r <= mask_in;
        steps <= is_shift ? cnt_in : 5'd1;
        if (zero_cnt) out_result <= in_a;
        else begin
          alu_op <= in_op;
          alu_size <= in_size;
          alu_a <= in_a;
          alu_b <= is_shift ? 16'd1 : in_b;
        end
      end
      if (!flush && state == EXEC) begin
        steps <= steps - 5'd1;
        if (last) begin
          out_result <= acc_nx;
          psw_flags <= (psw_flags & ~mask_r) | (f & mask_r);
        end else alu_a <= acc_nx;
      end
    end
  end
endmodule
